// File: rtl/avalon_st_pkg.sv
// Shared types for the 256-bit Avalon-ST path: beat record and packetizer states.
package avalon_st_pkg;

  localparam int DATA_W  = 256;
  localparam int EMPTY_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } avalon_st_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } pktz_state_e;

endpackage

// File: rtl/avalon_st_packetizer_if.sv
// Command, input word and Avalon-ST output signals of the packetizer, grouped as one bundle.
interface avalon_st_packetizer_if #(
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 5,
  parameter int LEN_W   = 16
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [LEN_W-1:0]   cmd_len;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_startofpacket;
  logic               out_endofpacket;
  logic [EMPTY_W-1:0] out_empty;
  logic               err_zero_len;
  logic               busy;

  modport master (
    output cmd_valid, cmd_len, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_data, out_valid, out_startofpacket,
           out_endofpacket, out_empty, err_zero_len, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_data, out_valid, out_startofpacket,
           out_endofpacket, out_empty, err_zero_len, busy
  );

endinterface

// File: rtl/avalon_st_skid2.sv
// Two-entry valid/ready buffer of Avalon-ST beats; the output side is driven only from registers.
module avalon_st_skid2
  import avalon_st_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push_valid,
  output logic            push_ready,
  input  avalon_st_beat_t push_beat,
  output logic            pop_valid,
  input  logic            pop_ready,
  output avalon_st_beat_t pop_beat
);

  avalon_st_beat_t mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_beat   = mem[rd_ptr];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avalon_st_packetizer.sv
// Turns a byte-length command plus headerless data words into Avalon-ST packets.
//   state | meaning
//   IDLE  | waiting for a length command; input words are held off
//   XFER  | moving words into the skid, sop on first, eop/empty on last
module avalon_st_packetizer #(
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 5,
  parameter int LEN_W   = 16
) (
  input logic                    clk,
  input logic                    reset,
  avalon_st_packetizer_if.slave  bus
);

  import avalon_st_pkg::avalon_st_beat_t;
  import avalon_st_pkg::pktz_state_e;
  import avalon_st_pkg::IDLE;
  import avalon_st_pkg::XFER;

  localparam int BL_W = LEN_W - EMPTY_W + 1;

  pktz_state_e        state, state_nxt;
  logic [BL_W-1:0]    beats_left, beats_nxt, cmd_beats;
  logic [EMPTY_W-1:0] last_empty, last_empty_nxt;
  logic               first, first_nxt;
  logic               err_q, err_nxt;
  logic               cmd_ready_c, in_ready_c;
  logic               push_valid, push_ready, pop_valid, last_beat;
  logic [DATA_W-1:0]  in_word;
  avalon_st_beat_t    push_beat, pop_beat;

  // ceil(len / BYTES) without a wide adder: whole words plus one for any remainder
  assign cmd_beats = {1'b0, bus.cmd_len[LEN_W-1:EMPTY_W]}
                   + BL_W'(|bus.cmd_len[EMPTY_W-1:0]);
  assign last_beat = (beats_left == BL_W'(1));
  assign in_word   = bus.in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beats_left <= '0;
      last_empty <= '0;
      first      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_nxt;
      last_empty <= last_empty_nxt;
      first      <= first_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    beats_nxt      = beats_left;
    last_empty_nxt = last_empty;
    first_nxt      = first;
    err_nxt        = 1'b0;
    cmd_ready_c    = 1'b0;
    in_ready_c     = 1'b0;
    push_valid     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0) begin
            err_nxt = 1'b1;
          end else begin
            beats_nxt      = cmd_beats;
            last_empty_nxt = EMPTY_W'(0) - bus.cmd_len[EMPTY_W-1:0];
            first_nxt      = 1'b1;
            state_nxt      = XFER;
          end
        end
      end
      XFER: begin
        in_ready_c = push_ready;
        push_valid = bus.in_valid;
        if (bus.in_valid && push_ready) begin
          first_nxt = 1'b0;
          beats_nxt = beats_left - BL_W'(1);
          if (last_beat) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push_beat.data  = in_word;
    push_beat.sop   = first;
    push_beat.eop   = last_beat;
    push_beat.empty = last_beat ? last_empty : '0;
  end

  avalon_st_skid2 u_skid (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_beat  (push_beat),
    .pop_valid  (pop_valid),
    .pop_ready  (bus.out_ready),
    .pop_beat   (pop_beat)
  );

  assign bus.cmd_ready         = cmd_ready_c;
  assign bus.in_ready          = in_ready_c;
  assign bus.out_valid         = pop_valid;
  assign bus.out_data          = pop_beat.data;
  assign bus.out_startofpacket = pop_beat.sop;
  assign bus.out_endofpacket   = pop_beat.eop;
  assign bus.out_empty         = pop_beat.empty;
  assign bus.err_zero_len      = err_q;
  assign bus.busy              = (state == XFER) || pop_valid;

endmodule

// File: tb/tb_avalon_st_packetizer.sv
// Scoreboard bench: commands enqueue expected beats, a monitor pops and compares on each output handshake.
module tb_avalon_st_packetizer;
  import avalon_st_pkg::*;

  localparam int DW    = 256;
  localparam int EW    = 5;
  localparam int LW    = 16;
  localparam int BYTES = DW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avalon_st_packetizer_if #(.DATA_W(DW), .EMPTY_W(EW), .LEN_W(LW)) bus ();

  avalon_st_packetizer #(.DATA_W(DW), .EMPTY_W(EW), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int beats_seen = 0;
  int sop_cyc  = 0;
  int eop_cyc  = 0;
  bit rand_in  = 1'b0;
  int out_mode = 0;

  avalon_st_beat_t exp_q [$];
  logic [DW-1:0]   word_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: split len bytes into ceil(len/BYTES) beats, padding counted on the last one
  task automatic enqueue_packet(input int len);
    int nb;
    avalon_st_beat_t b;
    logic [DW-1:0] w;
    nb = (len + BYTES - 1) / BYTES;
    for (int i = 0; i < nb; i++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      word_q.push_back(w);
      b.data  = w;
      b.sop   = (i == 0);
      b.eop   = (i == nb - 1);
      b.empty = (i == nb - 1) ? EW'(nb * BYTES - len) : '0;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_cmd(input int len);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("cmd_timeout", 0, 1);
    else enqueue_packet(len);
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20000; i++) begin
      if (exp_q.size() == 0 && word_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Output ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (out_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Input word driver
  initial begin
    bit taken;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      taken = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (taken && word_q.size() > 0) void'(word_q.pop_front());
      if (word_q.size() > 0 && (!rand_in || $urandom_range(0, 3) != 0)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = word_q[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = {8{$urandom()}};
      end
    end
  end

  // Monitor: compare each accepted beat and stability under backpressure
  initial begin
    avalon_st_beat_t cur, prev, e;
    bit hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.out_empty};
      if (hold && !reset) chk("stable", {bus.out_valid, cur}, {1'b1, prev});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        beats_seen++;
        if (cur.sop) sop_cyc = cyc;
        if (cur.eop) eop_cyc = cyc;
      end
      hold = bus.out_valid && !bus.out_ready && !reset;
      prev = cur;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, errs;
    bit bad_rdy, bad_vld;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sop_eop", {bus.out_startofpacket, bus.out_endofpacket}, 0);
    chk("rst_data_empty", {bus.out_data, bus.out_empty}, 0);
    chk("rst_err_busy", {bus.err_zero_len, bus.busy}, 0);
    chk("rst_ready", {bus.cmd_ready, bus.in_ready}, 2'b10);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {bus.cmd_ready, bus.in_ready, bus.busy}, 3'b100);

    // Two full words, back-to-back beats
    send_cmd(64);
    drain();
    chk("tput_64", eop_cyc - sop_cyc, 1);
    repeat (2) @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    // Partial last word
    send_cmd(33);
    drain();

    // Single-byte packet, FSM idle right after its push
    send_cmd(1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (word_q.size() == 0) break;
    end
    chk("len1_idle", {bus.cmd_ready, bus.in_ready}, 2'b10);
    drain();

    // Backpressure after the first beat
    send_cmd(96);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    @(posedge clk); #2;
    out_mode = 2;
    bus.out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_held", {bus.out_valid, bus.in_ready, bus.busy}, 3'b101);
    chk("bp_pending", exp_q.size(), 2);
    @(posedge clk); #2;
    out_mode = 0;
    bus.out_ready = 1'b1;
    drain();

    // Zero-length command
    send_cmd(0);
    errs = 0; bad_rdy = 1'b0; bad_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.err_zero_len) errs++;
      if (!bus.cmd_ready) bad_rdy = 1'b1;
      if (bus.out_valid) bad_vld = 1'b1;
    end
    chk("zero_err_pulses", errs, 1);
    chk("zero_ready_valid", {bad_rdy, bad_vld}, 0);

    // Reset mid-packet
    base = beats_seen;
    send_cmd(128);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (beats_seen >= base + 2) break;
    end
    @(posedge clk); #3;
    reset = 1'b1;
    word_q.delete();
    exp_q.delete();
    #1;
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_ready", {bus.cmd_ready, bus.in_ready, bus.busy}, 3'b100);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_after", {bus.cmd_ready, bus.out_valid}, 2'b10);
    send_cmd(32);
    drain();

    // Random traffic with random gaps and backpressure
    rand_in  = 1'b1;
    out_mode = 1;
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 3))
        0:       send_cmd(32 * $urandom_range(1, 6));
        1:       send_cmd($urandom_range(0, 3));
        default: send_cmd($urandom_range(1, 400));
      endcase
    end
    drain();

    // Maximum length: 2048 beats, empty of 1 on the last
    send_cmd(65535);
    drain();
    chk("max_len_beats", exp_q.size() + word_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_st_packetizer.md
# avalon_st_packetizer

Upstream source stage for the 256-bit Avalon-ST sink path. It takes a packet-length command plus a headerless stream of 256-bit data words and emits Avalon-ST beats: `startofpacket` on the first beat, `endofpacket` on the last, and `empty` giving the unused byte lanes of the last beat. The output is buffered by a 2-entry skid so downstream `ready` never reaches upstream combinationally.

## Interface
Parameters:
- `DATA_W`, default 256: data width in bits; must be a power of two and at least 16.
- `EMPTY_W`, default 5: equals log2(DATA_W/8).
- `LEN_W`, default 16: width of the packet length field, in bytes.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: command valid.
- `cmd_ready`  out  1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_len`  in  LEN_W: packet length in bytes.
- `in_valid`  in  1: data word valid.
- `in_ready`  out  1: data word accepted when `in_valid && in_ready`.
- `in_data`  in  DATA_W: payload word; byte 0 is `[7:0]`.
- `out_data`  out  DATA_W: Avalon-ST data.
- `out_valid`  out  1: Avalon-ST valid.
- `out_ready`  in  1: Avalon-ST ready (ready latency 0).
- `out_startofpacket`  out  1: first beat of a packet.
- `out_endofpacket`  out  1: last beat of a packet.
- `out_empty`  out  EMPTY_W: unused bytes on the last beat; 0 on all other beats.
- `err_zero_len`  out  1: one-cycle pulse when a command with `cmd_len == 0` is accepted.
- `busy`  out  1: high in XFER or whenever the skid is non-empty.

## Operation
- FSM has two states, IDLE and XFER.
- IDLE:
  - `cmd_ready = 1`, `in_ready = 0`.
  - On command handshake with `cmd_len != 0`:
    - latch `beats_left = (cmd_len + BYTES-1) >> EMPTY_W`, computed in LEN_W+1 bits, where BYTES = DATA_W/8;
    - latch `last_empty = (-cmd_len) & (BYTES-1)`;
    - set `first = 1`;
    - go to XFER.
  - On command handshake with `cmd_len == 0`: pulse `err_zero_len` and stay in IDLE.
- XFER:
  - `cmd_ready = 0`, `in_ready = (skid_count < 2)`.
  - Each accepted word pushes a beat into the skid:
    - data = `in_data`;
    - sop = `first`;
    - eop = `beats_left == 1`;
    - empty = eop ? `last_empty` : 0.
  - After each push: clear `first` and decrement `beats_left`.
  - The eop push returns the FSM to IDLE.
- Skid:
  - 2-entry FIFO; `out_*` come from the head entry; `out_valid = (skid_count != 0)`.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - A push can only occur when count < 2, so the skid cannot overflow.
- Avalon rules:
  - All `out_*` are held stable while `out_valid && !out_ready`.
  - `out_valid` never depends combinationally on `out_ready`.
- Extra input words arriving while in IDLE are not accepted; they wait for the next command.

## Timing
- Reset values:
  - `out_valid`, `out_startofpacket`, `out_endofpacket`, `err_zero_len`, `busy` = 0;
  - `out_data` = 0, `out_empty` = 0;
  - FSM in IDLE, skid empty.
- `cmd_ready` = 1 and `in_ready` = 0 during and after reset. Upstream must not assert `cmd_valid` while `reset` is high.
- Command accepted in cycle N: `in_ready` can assert in cycle N+1.
- Word accepted in cycle N: the beat is visible on `out_*` in cycle N+1 if the skid was empty.
- Throughput is 1 beat/cycle with `out_ready` held high.
- There is one IDLE cycle between the eop push and the next command acceptance.
- Backpressure: when `out_ready` is held low, at most 2 beats are buffered, then `in_ready` drops.
- Reset mid-packet:
  - immediately clears the FSM, counters and skid;
  - `out_valid` falls asynchronously;
  - the partial packet is discarded with no eop emitted.
- Maximum `cmd_len` (2^LEN_W − 1) gives 2048 beats at the defaults with no counter wrap. `beats_left` is LEN_W−EMPTY_W+1 bits.

## Structure
- Package `avalon_st_pkg` holds:
  - `DATA_W`, `EMPTY_W` constants;
  - typedef `avalon_st_beat_t` struct {data, sop, eop, empty};
  - typedef `pktz_state_e` {IDLE, XFER}.
- Sub-module `avalon_st_skid2`:
  - generic 2-entry valid/ready buffer of `avalon_st_beat_t`;
  - reused by other stages on the path.

## Test plan
- `cmd_len=64`, `out_ready=1`, 2 words → 2 beats; sop on beat 0; eop on beat 1 with empty=0; back-to-back cycles.
- `cmd_len=33` → 2 beats; last beat empty=31, eop=1.
- `cmd_len=1` → single beat with sop=eop=1, empty=31; FSM back in IDLE the next cycle.
- `cmd_len=96`, `out_ready` low for 5 cycles after the first beat → `in_ready` low once 2 beats are held; `out_*` stable; all 3 beats delivered in order, none lost.
- `cmd_len=0` → `err_zero_len` high for exactly 1 cycle; no `out_valid`; `cmd_ready` stays 1.
- `cmd_len=128`, reset asserted after 2 beats → `out_valid=0` during reset; after release `cmd_ready=1`; a following `cmd_len=32` gives one clean beat with sop=eop=1, empty=0.
